present80_key_schedule: RTL and testbench
=========================================

Name: present80_key_schedule

Overview:
- PRESENT-80 key-schedule stage that sits directly downstream of the 5-bit round counter and consumes its round value.
- Holds the 80-bit key register and presents round key K_i = key[79:16] to the round datapath.
- Applies one key update per advance pulse, XORing in the counter's round value, until K32 is produced.
- Cross-checks the incoming round value against an internal shadow count.

Parameters:
- KEY_W, 80, key register width; fixed for PRESENT-80 and not meant to be overridden.
- RK_W, 64, round-key width (KEY_W-16).
- LAST_ROUND, 31, round value whose update produces K32 and ends the schedule.
- CHECK_ROUND, 1, 1 enables the round_err comparison; 0 forces round_err low.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset; clears all state immediately.
- load  input  1  load key_in and start a new schedule.
- key_in  input  80  user key, sampled when load=1.
- round  input  5  current round value from the round counter (1..31).
- advance  input  1  apply one key update using round.
- round_key  output  64  current round key key_reg[79:16], registered.
- rk_valid  output  1  round_key is a valid K_i.
- last  output  1  round_key is K32 (final whitening key).
- round_err  output  1  sticky: round differed from the shadow count on an accepted advance.

Behaviour:
- Reset (async, active-high): key_reg=0, shadow=1, state=IDLE, rk_valid=0, last=0, round_err=0.
- States:
  - IDLE: no valid key.
  - RUN: K1..K31 presented.
  - DONE: K32 presented.
- load=1, any state: next edge key_reg<=key_in, shadow<=1, round_err<=0, state<=RUN. round_key=K1 and rk_valid=1 one cycle after the load edge.
- load has priority over advance in the same cycle; advance is ignored that cycle.
- advance=1 in RUN (load=0): next edge key_reg<=upd(key_reg, round) and shadow<=shadow+1 (5-bit). round_key reflects the update one cycle after the edge (latency 1).
- upd(k, r), in order:
  - rotate left by 61 (equivalently right by 19);
  - bits[79:76] <= S(bits[79:76]);
  - bits[19:15] ^= r.
- PRESENT S-box (hex, x=0..F): C 5 6 B 9 0 A D 3 E F 8 4 7 1 2.
- round is used exactly as presented; round=0 is applied (XOR of zero), not blocked.
- If CHECK_ROUND=1 and round!=shadow on an accepted advance: round_err<=1 and holds until the next load or reset. The update still proceeds with the port value.
- Accepted advance with round==LAST_ROUND: state<=DONE and last<=1 together with the K32 update.
- advance in IDLE or DONE: ignored; key_reg, shadow and outputs unchanged.
- In DONE: rk_valid=1 and last=1 hold until load or reset.
- Reset mid-schedule: all outputs go to reset values immediately, with no clock edge required.
- All outputs are registered or decoded from registers only; no input-to-output combinational path.

Decomposition:
- Shared package present80_pkg:
  - KEY_W, RK_W, LAST_ROUND;
  - the 16-entry S-box constant array;
  - state enum {IDLE, RUN, DONE}.
- Sub-module present_sbox (4-bit combinational lookup). It is reused by the round datapath's substitution layer, which instantiates 16 copies.

Test Plan:
- Reset asserted asynchronously mid-cycle -> outputs 0 immediately; after release, advance is ignored and rk_valid stays 0.
- load key_in=0 -> round_key=0x0000000000000000, rk_valid=1.
  - advance with round=1 -> round_key=0xC000000000000000.
  - advance with round=2 -> round_key=0x5000180000000001.
- load key=0, then 31 advances with round=1..31 back to back -> last=1 after the 31st edge; round_key equals the PRESENT-80 reference K32. The full cipher with plaintext 0 gives ciphertext 0x5579C1387B228445.
- Same run with round=4 on the 3rd advance -> round_err=1 and sticky; the key sequence diverges from the reference; a new load clears round_err.
- load and advance in the same cycle with key_in=0xFFFFFFFFFFFFFFFFFFFF -> round_key=0xFFFFFFFFFFFFFFFF, i.e. K1, no update.
- In DONE, pulse advance 3 times -> round_key, last and rk_valid unchanged. A mid-RUN load restarts the sequence at K1 with shadow=1.

Source files
------------

// File: rtl/present80_pkg.sv
// Shared constants and types for the PRESENT-80 key schedule and the
// round datapath's substitution layer.
package present80_pkg;

  localparam int KEY_W = 80;
  localparam int RK_W  = KEY_W - 16;
  localparam logic [4:0] LAST_ROUND = 5'd31;

  // PRESENT 4-bit S-box, indexed by input nibble 0..F.
  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/present_sbox.sv
// 4-bit PRESENT S-box lookup; purely combinational so it can be replicated
// across the 16 nibbles of the round datapath.
module present_sbox
  import present80_pkg::*;
(
  input  logic [3:0] x,
  output logic [3:0] y
);

  assign y = SBOX[x];

endmodule

// File: rtl/present80_key_schedule.sv
// PRESENT-80 key register: loads a user key, then applies one key update per
// advance pulse using the round counter's value, presenting K1..K32.
module present80_key_schedule
  import present80_pkg::*;
#(
  parameter int CHECK_ROUND = 1
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [KEY_W-1:0] key_in,
  input  logic [4:0]       round,
  input  logic             advance,
  output logic [RK_W-1:0]  round_key,
  output logic             rk_valid,
  output logic             last,
  output logic             round_err,
  output state_e           state
);

  // Handshake: load and advance are single-cycle strobes with no back-pressure;
  // load wins over advance, and advance is only accepted in RUN.
  logic [KEY_W-1:0] key_reg;
  logic [4:0]       shadow;
  logic [KEY_W-1:0] rot;
  logic [KEY_W-1:0] upd_key;
  logic [3:0]       sb_out;

  // Rotate left by 61 is the same as rotate right by 19.
  assign rot = {key_reg[18:0], key_reg[KEY_W-1:19]};

  present_sbox u_sbox (
    .x (rot[79:76]),
    .y (sb_out)
  );

  always_comb begin
    upd_key         = rot;
    upd_key[79:76]  = sb_out;
    upd_key[19:15]  = rot[19:15] ^ round;
  end

  assign round_key = key_reg[KEY_W-1:16];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_reg   <= '0;
      shadow    <= 5'd1;
      state     <= IDLE;
      rk_valid  <= 1'b0;
      last      <= 1'b0;
      round_err <= 1'b0;
    end else if (load) begin
      key_reg   <= key_in;
      shadow    <= 5'd1;
      state     <= RUN;
      rk_valid  <= 1'b1;
      last      <= 1'b0;
      round_err <= 1'b0;
    end else if (advance && state == RUN) begin
      key_reg <= upd_key;
      shadow  <= shadow + 5'd1;
      // A mismatch is flagged but the port value is still applied.
      if (CHECK_ROUND != 0 && round != shadow) begin
        round_err <= 1'b1;
      end
      if (round == LAST_ROUND) begin
        state <= DONE;
        last  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_present80_key_schedule.sv
// Directed bench for present80_key_schedule: hand-computed early round keys,
// a bit-level key-schedule model cross-checked by the PRESENT-80 ciphertext.
module tb_present80_key_schedule;
  import present80_pkg::*;

  logic            clk;
  logic            reset;
  logic            load;
  logic [79:0]     key_in;
  logic [4:0]      round;
  logic            advance;
  logic [63:0]     round_key;
  logic            rk_valid;
  logic            last;
  logic            round_err;
  state_e          state;

  int total = 0;
  int bad   = 0;

  logic [3:0]  sb [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  logic [79:0] model_key;
  logic [63:0] ct;
  localparam logic [63:0] REF_CT = 64'h5579C1387B228445;

  present80_key_schedule #(.CHECK_ROUND(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .key_in    (key_in),
    .round     (round),
    .advance   (advance),
    .round_key (round_key),
    .rk_valid  (rk_valid),
    .last      (last),
    .round_err (round_err),
    .state     (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference model, written as a bitwise rotate rather than a slice concat
  function automatic logic [79:0] ks_next(input logic [79:0] k, input logic [4:0] r);
    logic [79:0] n;
    for (int i = 0; i < 80; i++) n[i] = k[(i + 19) % 80];
    n[79:76] = sb[n[79:76]];
    n[19:15] = n[19:15] ^ r;
    return n;
  endfunction

  function automatic logic [63:0] present_enc(input logic [63:0] pt, input logic [63:0] rk [32]);
    logic [63:0] s;
    logic [63:0] t;
    s = pt;
    for (int rr = 0; rr < 31; rr++) begin
      s = s ^ rk[rr];
      for (int n = 0; n < 16; n++) s[n*4 +: 4] = sb[s[n*4 +: 4]];
      for (int j = 0; j < 64; j++) t[(j == 63) ? 63 : (j * 16) % 63] = s[j];
      s = t;
    end
    return s ^ rk[31];
  endfunction

  // driver tasks
  task automatic do_load(input logic [79:0] k);
    key_in = k;
    load   = 1'b1;
    @(posedge clk); #1;
    load   = 1'b0;
  endtask

  task automatic do_adv(input logic [4:0] r);
    round   = r;
    advance = 1'b1;
    @(posedge clk); #1;
    advance = 1'b0;
  endtask

  // Zero key, rounds 1..31 except the third advance uses r3.
  task automatic run_sched(input logic [4:0] r3, output logic [63:0] ct_o);
    logic [63:0] rks [32];
    logic [4:0]  r;
    do_load(80'h0);
    model_key = '0;
    check("k1", {16'h0, round_key}, {16'h0, model_key[79:16]});
    rks[0] = model_key[79:16];
    for (int a = 1; a <= 31; a++) begin
      r = (a == 3) ? r3 : 5'(a);
      do_adv(r);
      model_key = ks_next(model_key, r);
      rks[a] = model_key[79:16];
      check($sformatf("k%0d", a + 1), {16'h0, round_key}, {16'h0, model_key[79:16]});
      check($sformatf("last%0d", a + 1), {79'h0, last}, {79'h0, (a == 31)});
      check($sformatf("err%0d", a + 1), {79'h0, round_err}, {79'h0, (r3 != 5'd3 && a >= 3)});
    end
    ct_o = present_enc(64'h0, rks);
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; key_in = '0; round = '0; advance = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rk",    {16'h0, round_key}, 80'h0);
    check("rst_valid", {79'h0, rk_valid},  80'h0);
    check("rst_state", {78'h0, state},     {78'h0, IDLE});
    reset = 1'b0;
    do_adv(5'd1);
    check("idle_adv_valid", {79'h0, rk_valid}, 80'h0);
    check("idle_adv_rk",    {16'h0, round_key}, 80'h0);

    // hand-computed early keys from a zero key
    do_load(80'h0);
    check("z_k1",    {16'h0, round_key}, 80'h0);
    check("z_valid", {79'h0, rk_valid},  80'h1);
    do_adv(5'd1);
    check("z_k2", {16'h0, round_key}, {16'h0, 64'hC000000000000000});
    do_adv(5'd2);
    check("z_k3", {16'h0, round_key}, {16'h0, 64'h5000180000000001});
    do_adv(5'd3);
    check("z_k4", {16'h0, round_key}, {16'h0, 64'h60000A0003000001});

    // mid-RUN reload restarts at K1 with shadow back at 1
    do_load(80'h0);
    check("reload_k1", {16'h0, round_key}, 80'h0);
    do_adv(5'd1);
    check("reload_k2",  {16'h0, round_key}, {16'h0, 64'hC000000000000000});
    check("reload_err", {79'h0, round_err}, 80'h0);

    // full clean schedule validated by the known ciphertext
    run_sched(5'd3, ct);
    check("ct_ref",     {16'h0, ct}, {16'h0, REF_CT});
    check("done_state", {78'h0, state}, {78'h0, DONE});
    check("done_valid", {79'h0, rk_valid}, 80'h1);
    for (int i = 0; i < 3; i++) begin
      do_adv(5'(i + 1));
      check("done_hold_rk",   {16'h0, round_key}, {16'h0, model_key[79:16]});
      check("done_hold_last", {79'h0, last}, 80'h1);
      check("done_hold_vld",  {79'h0, rk_valid}, 80'h1);
    end

    // wrong round on the third advance
    do_load(80'h0);
    do_adv(5'd1);
    do_adv(5'd2);
    do_adv(5'd4);
    check("bad_k4",  {16'h0, round_key}, {16'h0, 64'h60000A0003000002});
    check("bad_err", {79'h0, round_err}, 80'h1);
    run_sched(5'd4, ct);
    check("bad_ct_differs", {79'h0, (ct !== REF_CT)}, 80'h1);
    do_load(80'h0);
    check("clr_err", {79'h0, round_err}, 80'h0);

    // load beats advance in the same cycle
    key_in = {80{1'b1}}; load = 1'b1; advance = 1'b1; round = 5'd1;
    @(posedge clk); #1;
    load = 1'b0; advance = 1'b0;
    check("ld_adv_rk",   {16'h0, round_key}, {16'h0, 64'hFFFFFFFFFFFFFFFF});
    check("ld_adv_last", {79'h0, last}, 80'h0);

    // async reset mid-cycle with err and key non-zero
    do_adv(5'd1);
    do_adv(5'd5);
    check("pre_rst_err", {79'h0, round_err}, 80'h1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_rk",    {16'h0, round_key}, 80'h0);
    check("arst_valid", {79'h0, rk_valid},  80'h0);
    check("arst_last",  {79'h0, last},      80'h0);
    check("arst_err",   {79'h0, round_err}, 80'h0);
    @(negedge clk);
    reset = 1'b0;
    do_adv(5'd1);
    check("post_rst_valid", {79'h0, rk_valid}, 80'h0);
    check("post_rst_rk",    {16'h0, round_key}, 80'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
